// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search scheduler.
// Printable range and the pt-memory length-byte address live here.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, BUSY, RUN, CHECK, FOUND, EXHAUSTED
  } sched_state_t;

  localparam logic [7:0] PT_MIN      = 8'h20;
  localparam logic [7:0] PT_MAX      = 8'h7E;
  localparam logic [7:0] PT_LEN_ADDR = 8'd0;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PT_MIN) && (b <= PT_MAX);
  endfunction

endpackage

// File: rtl/arc4_pt_check.sv
// Snoops pt-memory writes and keeps a sticky "unreadable byte seen" flag.
// Set is combinational on the write; clr wins over set and is applied at attempt start.
module arc4_pt_check
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       chk_en,
  input  logic       pt_wren,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  output logic       bad
);

  logic set_bad;

  // The length byte at address 0 is never part of the message.
  assign set_bad = chk_en && pt_wren && (pt_addr != PT_LEN_ADDR) && !is_printable(pt_wrdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bad <= 1'b0;
    else if (clr)     bad <= 1'b0;
    else if (set_bad) bad <= 1'b1;
  end

endmodule

// File: rtl/arc4_key_sched.sv
// Steps one arc4 core over keys KEY_START, +KEY_STEP.. until a readable plaintext or KEY_LAST; 3 cycles overhead per key.
// en is taken only while rdy=1; define ARC4_KEY_SCHED_WDOG_EN to add a core watchdog driving err.
module arc4_key_sched
  import arc4_pkg::*;
#(
  parameter int               KEY_W       = 24,
  parameter logic [KEY_W-1:0] KEY_START   = '0,
  parameter logic [KEY_W-1:0] KEY_STEP    = KEY_W'(1),
  parameter logic [KEY_W-1:0] KEY_LAST    = '1,
  parameter int               TIMEOUT_CYC = 2**20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  output logic             core_en,
  input  logic             core_rdy,
  input  logic             pt_wren,
  input  logic [7:0]       pt_addr,
  input  logic [7:0]       pt_wrdata,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             done,
  output logic             err
);

  sched_state_t     state, state_nxt;
  logic [KEY_W-1:0] key_nxt;
  logic             key_valid_nxt, done_nxt;
  logic             bad, bad_clr, chk_en, accept, last_key, wd_trip;
  logic [KEY_W:0]   key_sum;

  assign rdy    = (state == IDLE) || (state == FOUND) || (state == EXHAUSTED);
  assign accept = rdy && en;

  // Extra bit keeps key+STEP from wrapping past the top of the key space.
  assign key_sum  = {1'b0, key} + {1'b0, KEY_STEP};
  assign last_key = key_sum > {1'b0, KEY_LAST};

  arc4_pt_check u_pt_check (
    .clk       (clk),
    .rst       (rst),
    .clr       (bad_clr),
    .chk_en    (chk_en),
    .pt_wren   (pt_wren),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .bad       (bad)
  );

`ifdef ARC4_KEY_SCHED_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_trip = ((state == BUSY) || (state == RUN)) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wd_cnt <= '0;
    else if (core_en)                          wd_cnt <= '0;
    else if ((state == BUSY) || (state == RUN)) wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (wd_trip) err <= 1'b1;
    else if (accept)  err <= 1'b0;
  end
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    key_nxt       = key;
    key_valid_nxt = key_valid;
    done_nxt      = done;
    core_en       = 1'b0;
    bad_clr       = 1'b0;
    chk_en        = 1'b0;
    case (state)
      IDLE, FOUND, EXHAUSTED: begin
        if (en) begin
          key_nxt       = KEY_START;
          key_valid_nxt = 1'b0;
          done_nxt      = 1'b0;
          state_nxt     = LAUNCH;
        end
      end
      LAUNCH: begin
        if (core_rdy) begin
          core_en   = 1'b1;
          bad_clr   = 1'b1;
          state_nxt = BUSY;
        end
      end
      // Wait for the core to drop rdy so a stale rdy cannot end the attempt.
      BUSY: if (!core_rdy) state_nxt = RUN;
      RUN: begin
        chk_en = 1'b1;
        if (core_rdy) state_nxt = CHECK;
      end
      CHECK: begin
        if (!bad) begin
          key_valid_nxt = 1'b1;
          done_nxt      = 1'b1;
          state_nxt     = FOUND;
        end else if (last_key) begin
          key_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = EXHAUSTED;
        end else begin
          key_nxt   = key + KEY_STEP;
          state_nxt = LAUNCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wd_trip) begin
      key_nxt       = key;
      key_valid_nxt = 1'b0;
      done_nxt      = 1'b1;
      state_nxt     = EXHAUSTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key       <= KEY_START;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      key       <= key_nxt;
      key_valid <= key_valid_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_arc4_key_sched.sv
// Bench for arc4_key_sched: behavioural 40-cycle core model, vector table plus random vectors.
// Watchdog check is compiled in when ARC4_KEY_SCHED_WDOG_EN is defined.
module tb_arc4_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en0, en1, core_rdy, pt_wren;
  logic [7:0]  pt_addr, pt_wrdata;
  logic        rdy0, rdy1, core_en0, core_en1, kv0, kv1, done0, done1, err0, err1;
  logic [23:0] key0, key1;

  arc4_key_sched #(.KEY_W(24), .KEY_START(24'h000000), .KEY_STEP(24'd1),
                   .KEY_LAST(24'hFFFFFF), .TIMEOUT_CYC(100)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .core_en(core_en0), .core_rdy(core_rdy),
    .pt_wren(pt_wren), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
    .key(key0), .key_valid(kv0), .done(done0), .err(err0));

  arc4_key_sched #(.KEY_W(24), .KEY_START(24'hFFFFFC), .KEY_STEP(24'd1),
                   .KEY_LAST(24'hFFFFFF), .TIMEOUT_CYC(100)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .core_en(core_en1), .core_rdy(core_rdy),
    .pt_wren(pt_wren), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
    .key(key1), .key_valid(kv1), .done(done1), .err(err1));

  logic        sel;
  logic        cur_rdy, cur_cen, cur_kv, cur_done, cur_err;
  logic [23:0] cur_key;
  assign cur_rdy  = sel ? rdy1 : rdy0;
  assign cur_cen  = sel ? core_en1 : core_en0;
  assign cur_kv   = sel ? kv1 : kv0;
  assign cur_done = sel ? done1 : done0;
  assign cur_err  = sel ? err1 : err0;
  assign cur_key  = sel ? key1 : key0;

  int total = 0;
  int bad_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Core model configuration: attempt index cfg_good decrypts to readable text.
  int cfg_good = -1;
  bit cfg_late = 0, cfg_byte0 = 0, cfg_hang = 0, abort = 0;
  int launches = 0;

  function automatic logic [7:0] rand_bad();
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 31));
    return 8'($urandom_range(127, 255));
  endfunction

  task automatic run_attempt(input int idx);
    logic [7:0] b [0:8];
    bit ok;
    int p;
    ok = (idx == cfg_good);
    b[0] = cfg_byte0 ? 8'h05 : 8'h08;
    for (int a = 1; a <= 8; a++) b[a] = cfg_byte0 ? 8'h41 : 8'($urandom_range(32, 126));
    if (ok && !cfg_byte0) begin b[1] = 8'h20; b[2] = 8'h7E; end
    if (!ok && !(cfg_late && idx == 0)) begin
      p = $urandom_range(1, 8);
      b[p] = rand_bad();
    end
    if (cfg_hang) begin
      @(negedge clk); core_rdy = 1'b0;
      while (!abort) @(negedge clk);
      core_rdy = 1'b1;
      return;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (abort) begin core_rdy = 1'b1; pt_wren = 1'b0; return; end
      pt_wren = 1'b0;
      if (c == 1) core_rdy = 1'b0;
      if (c >= 2 && c <= 10) begin pt_wren = 1'b1; pt_addr = 8'(c - 2); pt_wrdata = b[c-2]; end
      if (c == 11) begin pt_wren = 1'b1; pt_addr = 8'd1; pt_wrdata = b[1]; end
      if (c == 40) begin
        core_rdy = 1'b1;
        if (cfg_late && idx == 0) begin pt_wren = 1'b1; pt_addr = 8'd5; pt_wrdata = 8'h7F; end
      end
    end
    @(negedge clk);
    pt_wren = 1'b0;
  endtask

  initial begin
    core_rdy = 1'b1; pt_wren = 1'b0; pt_addr = '0; pt_wrdata = '0;
    forever begin
      @(negedge clk);
      if (!abort && cur_cen) begin
        launches++;
        run_attempt(launches - 1);
      end
    end
  end

  // Reference: walk the key sequence arithmetically until the readable attempt or the last key.
  function automatic void ref_search(input longint start, input longint step, input longint last,
                                     input int good, output logic [23:0] k_o, output bit v_o,
                                     output int n_o);
    longint k = start;
    k_o = '0; v_o = 0; n_o = 0;
    for (int n = 1; n <= 64; n++) begin
      if (n - 1 == good) begin k_o = k[23:0]; v_o = 1; n_o = n; return; end
      if (k + step > last) begin k_o = k[23:0]; v_o = 0; n_o = n; return; end
      k = k + step;
    end
  endfunction

  typedef struct {
    bit          sel;
    int          good;
    bit          late;
    bit          byte0;
    logic [23:0] exp_key;
    bit          exp_valid;
    int          exp_launch;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic prev_rdy;
    int n;
    sel = v.sel; cfg_good = v.good; cfg_late = v.late; cfg_byte0 = v.byte0;
    launches = 0;
    if (v.sel) en1 = 1'b1; else en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0; en1 = 1'b0;
    chk("rdy_drop", 32'(cur_rdy), 32'd0);
    chk("core_en_first", 32'(cur_cen), 32'd1);
    prev_rdy = cur_rdy;
    for (n = 0; n < 3000 && !cur_done; n++) begin
      // A stray en mid-search must be ignored.
      if (v.sel) en1 = (n == 50); else en0 = (n == 50);
      prev_rdy = cur_rdy;
      @(negedge clk);
    end
    en0 = 1'b0; en1 = 1'b0;
    chk("done", 32'(cur_done), 32'd1);
    chk("rdy_with_done", 32'(cur_rdy), 32'd1);
    chk("rdy_before_done", 32'(prev_rdy), 32'd0);
    chk("key", 32'(cur_key), 32'(v.exp_key));
    chk("key_valid", 32'(cur_kv), 32'(v.exp_valid));
    chk("launches", 32'(launches), 32'(v.exp_launch));
    chk("err", 32'(cur_err), 32'd0);
    repeat (5) @(negedge clk);
    chk("key_hold", 32'(cur_key), 32'(v.exp_key));
    chk("done_hold", 32'(cur_done), 32'd1);
    chk("launch_hold", 32'(launches), 32'(v.exp_launch));
  endtask

  initial begin
    vec_t vt [10];
    vec_t vr;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_core_en", 32'(core_en0), 32'd0);
    chk("rst_key0", 32'(key0), 32'h000000);
    chk("rst_key1", 32'(key1), 32'hFFFFFC);
    chk("rst_kv", 32'(kv0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vt[0] = '{sel: 0, good: 3,  late: 0, byte0: 0, exp_key: 24'h000003, exp_valid: 1, exp_launch: 4};
    vt[1] = '{sel: 1, good: -1, late: 0, byte0: 0, exp_key: 24'hFFFFFF, exp_valid: 0, exp_launch: 4};
    vt[2] = '{sel: 0, good: 0,  late: 0, byte0: 1, exp_key: 24'h000000, exp_valid: 1, exp_launch: 1};
    vt[3] = '{sel: 0, good: 1,  late: 1, byte0: 0, exp_key: 24'h000001, exp_valid: 1, exp_launch: 2};
    for (int i = 4; i < 10; i++) begin
      vt[i].sel   = 1'($urandom_range(0, 1));
      vt[i].good  = $urandom_range(0, 5);
      vt[i].late  = (vt[i].good > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      vt[i].byte0 = 1'($urandom_range(0, 1));
      ref_search(vt[i].sel ? 64'hFFFFFC : 64'h0, 64'd1, 64'hFFFFFF, vt[i].good,
                 vt[i].exp_key, vt[i].exp_valid, vt[i].exp_launch);
    end
    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Reset in the middle of the third attempt, then a clean search.
    sel = 1'b0; cfg_good = 5; cfg_late = 0; cfg_byte0 = 0; launches = 0;
    en0 = 1'b1; @(negedge clk); en0 = 1'b0;
    repeat (110) @(negedge clk);
    abort = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rdy", 32'(rdy0), 32'd1);
    chk("midrst_key", 32'(key0), 32'h000000);
    chk("midrst_done", 32'(done0), 32'd0);
    repeat (3) @(negedge clk);
    abort = 1'b0;
    vr = '{sel: 0, good: 2, late: 0, byte0: 0, exp_key: 24'h000002, exp_valid: 1, exp_launch: 3};
    run_vec(vr);

`ifdef ARC4_KEY_SCHED_WDOG_EN
    sel = 1'b0; cfg_hang = 1; launches = 0;
    en0 = 1'b1; @(negedge clk); en0 = 1'b0;
    repeat (100) @(negedge clk);
    chk("wdog_early", 32'(done0), 32'd0);
    @(negedge clk);
    chk("wdog_done", 32'(done0), 32'd1);
    chk("wdog_err", 32'(err0), 32'd1);
    chk("wdog_kv", 32'(kv0), 32'd0);
    chk("wdog_key", 32'(key0), 32'h000000);
    chk("wdog_rdy", 32'(rdy0), 32'd1);
    abort = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cfg_hang = 0;
    repeat (2) @(negedge clk);
    abort = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule

// File: doc/arc4_key_sched.md
Name: arc4_key_sched

Overview:
- Key-search scheduler for the brute-force ARC4 cracker.
- Sequences one arc4 decrypt core (init/KSA/PRGA into the pt memory) over successive 24-bit keys.
- Snoops the core's pt-memory write port and classifies each decryption as readable (every message byte in 0x20..0x7E) or not.
- Stops at the first readable key or at the end of the key range. Sits between the top level (KEY/SW/HEX) and the core. Two instances with STEP=2 and START=0/1 split the key space across dual cores.

Parameters:
- KEY_W, 24, key width in bits.
- KEY_START, 0, first key tried after each en.
- KEY_STEP, 1, key increment per failed attempt (1..2**KEY_W-1).
- KEY_LAST, 24'hFFFFFF, highest key allowed.
- TIMEOUT_CYC, 2**20, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start-search pulse; sampled only while rdy=1.
- rdy  out  1  scheduler idle or finished; able to accept en.
- core_en  out  1  one-cycle start pulse to the arc4 core.
- core_rdy  in  1  core ready/idle (same en/rdy protocol as the rest of the codebase).
- pt_wren  in  1  core pt-memory write enable (snooped).
- pt_addr  in  8  core pt-memory write address.
- pt_wrdata  in  8  core pt-memory write data.
- key  out  KEY_W  key under test; holds the found key when key_valid=1.
- key_valid  out  1  search ended with a readable key.
- done  out  1  search ended, found or exhausted.
- err  out  1  core watchdog tripped (optional feature; tied 0 otherwise).

Behaviour:
- Reset values: state IDLE, rdy=1, core_en=0, key=KEY_START, key_valid=0, done=0, err=0, bad=0.
- Handshake: en is honoured only in IDLE/FOUND/EXHAUSTED with rdy=1. rdy drops the cycle after en is accepted and stays low until FOUND/EXHAUSTED. en with rdy=0 is ignored.
- IDLE, FOUND or EXHAUSTED with en: key<=KEY_START, key_valid<=0, done<=0, err<=0, go to LAUNCH.
- LAUNCH: wait for core_rdy=1, then assert core_en for exactly 1 cycle, clear bad, go to BUSY. core_en is therefore high 1 cycle after the en cycle at the earliest.
- BUSY: wait for core_rdy=0, meaning the core accepted the start, then go to RUN. This prevents a stale core_rdy=1 from ending the attempt early.
- RUN: set bad when pt_wren=1, pt_addr!=0 and (pt_wrdata<8'h20 or pt_wrdata>8'h7E). Address 0 is the length byte and is never checked. When core_rdy=1, go to CHECK.
- CHECK (1 cycle):
  - If bad=0: go to FOUND, key_valid<=1, done<=1.
  - Else if key > KEY_LAST-KEY_STEP (computed in KEY_W+1 bits, so no wrap): go to EXHAUSTED, done<=1, key_valid<=0, key holds the last key tried.
  - Else: key<=key+KEY_STEP and go to LAUNCH.
- pt writes with the same data at the same address count the same as a single write. bad is sticky within an attempt.
- A pt_wren in the same cycle that core_rdy rises is still checked before CHECK.
- FOUND and EXHAUSTED hold all outputs stable until en or rst.
- rst mid-search returns to IDLE immediately. The top level must reset the core on the same rst.
- Per-key overhead: 3 cycles (LAUNCH, BUSY, CHECK) plus core latency.

Optional Feature:
- Macro ARC4_KEY_SCHED_WDOG_EN.
- With the macro: a cycle counter clears on entering BUSY and counts in BUSY and RUN. If it reaches TIMEOUT_CYC, go to EXHAUSTED with err=1, done=1, key_valid=0, key frozen.
- Without the macro: no counter, err is tied 0, and TIMEOUT_CYC is unused.

Decomposition:
- Package arc4_pkg holds:
  - state enum sched_state_t (IDLE, LAUNCH, BUSY, RUN, CHECK, FOUND, EXHAUSTED);
  - PT_MIN=8'h20, PT_MAX=8'h7E;
  - localparam PT_LEN_ADDR=8'd0.
- One natural sub-module, arc4_pt_check: combinational printable test plus the sticky bad flop with clear and set inputs.

Test Plan:
- Behavioural core model (fixed 40-cycle latency after core_en; writes length then bytes) made readable only for key 24'h000003, en pulsed after rst → core_en fires 4 times; done=1, key_valid=1, key=24'h000003; rdy rises the same cycle as done.
- Model never readable; KEY_START=24'hFFFFFC, STEP=1 → 4 attempts, then done=1, key_valid=0, key=24'hFFFFFF, no wrap to 0.
- Only byte 0 is 8'h05 (non-printable) and the rest are 'A' (8'h41) → found on the first key; length byte ignored.
- Bad byte 8'h7F written in the same cycle core_rdy rises → attempt rejected, key increments to 1.
- rst asserted mid-RUN for 1 cycle → rdy=1, key=KEY_START, done=0 the following cycle; a new en runs cleanly.
- With ARC4_KEY_SCHED_WDOG_EN, TIMEOUT_CYC=100, model never raises core_rdy → err=1, done=1 at cycle 100 of BUSY/RUN.
